riscv_core_muldiv_issue: RTL and testbench

- Core-side initiator for the pipelined mul/div unit's val/rdy request and response interface.
- Accepts mul/div/rem instructions from the X stage and issues 67-bit-equivalent requests (fn, a, b).
- Tracks the destination register of each in-flight op in an in-order tag FIFO and selects the correct 32-bit half of each 64-bit response.
- Presents a registered writeback and a busy-register mask so the stall logic can block RAW/WAW hazards.

---
 rtl/riscv_core_muldiv_issue_pkg.sv | 30 +++
 rtl/riscv_core_muldiv_tag_fifo.sv | 51 +++++
 rtl/riscv_core_muldiv_issue.sv | 120 ++++++++++++
 tb/tb_riscv_core_muldiv_issue.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_muldiv_issue_pkg.sv
// Shared definitions for the mul/div issue block: function codes, tag layout, result halves.
package riscv_core_muldiv_issue_pkg;

   typedef enum logic [2:0] {
      FnMul  = 3'd0,
      FnDiv  = 3'd1,
      FnDivu = 3'd2,
      FnRem  = 3'd3,
      FnRemu = 3'd4
   } muldiv_fn_e;

   localparam int unsigned TagRdW     = 5;
   localparam int unsigned TagW       = TagRdW + 1;
   localparam int unsigned TagRdLsb   = 1;
   localparam int unsigned TagHselBit = 0;

   localparam int unsigned HalfW    = 32;
   localparam int unsigned ResLoLsb = 0;
   localparam int unsigned ResHiLsb = 32;

   typedef struct packed {
      logic [TagRdW-1:0] rd;
      logic              hsel;
   } muldiv_tag_t;

   function automatic logic [HalfW-1:0] sel_half(input logic [63:0] result, input logic hsel);
      return hsel ? result[ResHiLsb +: HalfW] : result[ResLoLsb +: HalfW];
   endfunction

endpackage

// File: rtl/riscv_core_muldiv_tag_fifo.sv
// In-order tag FIFO ({rd, hsel}) for ops between request fire and response fire.
module riscv_core_muldiv_tag_fifo
   import riscv_core_muldiv_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  muldiv_tag_t      push_tag,
   input  logic             pop,
   output muldiv_tag_t      pop_tag,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   muldiv_tag_t        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     count_q;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign pop_tag = mem[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end
   end

   // Storage carries no reset; entries are only read once the count covers them.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_tag;
   end

endmodule

// File: rtl/riscv_core_muldiv_issue.sv
// Core-side val/rdy initiator for the mul/div unit with tag tracking and registered writeback.
// Optional MULH writeback selection: define RISCV_MULDIV_ISSUE_MULH_EN.
module riscv_core_muldiv_issue
   import riscv_core_muldiv_issue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             x_val,
   output logic             x_rdy,
   input  logic [2:0]       x_fn,
   input  logic [31:0]      x_a,
   input  logic [31:0]      x_b,
   input  logic [4:0]       x_rd,
   input  logic             x_mulh,
   output logic [2:0]       muldivreq_msg_fn,
   output logic [31:0]      muldivreq_msg_a,
   output logic [31:0]      muldivreq_msg_b,
   output logic             muldivreq_val,
   input  logic             muldivreq_rdy,
   input  logic [63:0]      muldivresp_msg_result,
   input  logic             muldivresp_val,
   output logic             muldivresp_rdy,
   output logic             wb_val,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   input  logic             wb_rdy,
   output logic [31:0]      busy_mask,
   output logic [PTR_W+1:0] inflight
);

   logic            fifo_full;
   logic            fifo_empty;
   logic [PTR_W:0]  fifo_count;
   muldiv_tag_t     push_tag;
   muldiv_tag_t     pop_tag;
   logic            block;
   logic            hsel;
   logic            issue_fire;
   logic            resp_fire;
   logic            wb_fire;
   logic            wb_full_q;
   logic [4:0]      wb_rd_q;
   logic [31:0]     wb_data_q;
   logic [31:0]     busy_q;
   logic [31:0]     busy_d;

   assign muldivreq_msg_fn = x_fn;
   assign muldivreq_msg_a  = x_a;
   assign muldivreq_msg_b  = x_b;

   // A pending write to rd blocks until its writeback has retired, so set/clear never collide.
   assign block         = fifo_full | (busy_q[x_rd] & (x_rd != 5'd0));
   assign muldivreq_val = x_val & ~block;
   assign x_rdy         = muldivreq_rdy & ~block;
   assign issue_fire    = x_val & x_rdy;

`ifdef RISCV_MULDIV_ISSUE_MULH_EN
   assign hsel = (x_fn == FnRem) | (x_fn == FnRemu) | ((x_fn == FnMul) & x_mulh);
`else
   logic unused_mulh;
   assign unused_mulh = x_mulh;
   assign hsel        = (x_fn == FnRem) | (x_fn == FnRemu);
`endif

   assign push_tag = '{rd: x_rd, hsel: hsel};

   assign muldivresp_rdy = ~fifo_empty & (~wb_full_q | wb_rdy);
   assign resp_fire      = muldivresp_val & muldivresp_rdy;
   assign wb_fire        = wb_full_q & wb_rdy;

   riscv_core_muldiv_tag_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_tag_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (issue_fire),
      .push_tag (push_tag),
      .pop      (resp_fire),
      .pop_tag  (pop_tag),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_full_q <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else if (resp_fire) begin
         wb_full_q <= 1'b1;
         wb_rd_q   <= pop_tag.rd;
         wb_data_q <= sel_half(muldivresp_msg_result, pop_tag.hsel);
      end else if (wb_fire) begin
         wb_full_q <= 1'b0;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (wb_fire) busy_d[wb_rd_q] = 1'b0;
      if (issue_fire && (x_rd != 5'd0)) busy_d[x_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   assign wb_val    = wb_full_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign busy_mask = busy_q;
   assign inflight  = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, wb_full_q};

endmodule

// File: tb/tb_riscv_core_muldiv_issue.sv
// Self-checking bench for riscv_core_muldiv_issue: vector table, unit model and wb scoreboard.
module tb_riscv_core_muldiv_issue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic             clk;
   logic             reset_n;
   logic             x_val;
   logic             x_rdy;
   logic [2:0]       x_fn;
   logic [31:0]      x_a;
   logic [31:0]      x_b;
   logic [4:0]       x_rd;
   logic             x_mulh;
   logic [2:0]       muldivreq_msg_fn;
   logic [31:0]      muldivreq_msg_a;
   logic [31:0]      muldivreq_msg_b;
   logic             muldivreq_val;
   logic             muldivreq_rdy;
   logic [63:0]      muldivresp_msg_result;
   logic             muldivresp_val;
   logic             muldivresp_rdy;
   logic             wb_val;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             wb_rdy;
   logic [31:0]      busy_mask;
   logic [PTR_W+1:0] inflight;

   riscv_core_muldiv_issue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .x_val                 (x_val),
      .x_rdy                 (x_rdy),
      .x_fn                  (x_fn),
      .x_a                   (x_a),
      .x_b                   (x_b),
      .x_rd                  (x_rd),
      .x_mulh                (x_mulh),
      .muldivreq_msg_fn      (muldivreq_msg_fn),
      .muldivreq_msg_a       (muldivreq_msg_a),
      .muldivreq_msg_b       (muldivreq_msg_b),
      .muldivreq_val         (muldivreq_val),
      .muldivreq_rdy         (muldivreq_rdy),
      .muldivresp_msg_result (muldivresp_msg_result),
      .muldivresp_val        (muldivresp_val),
      .muldivresp_rdy        (muldivresp_rdy),
      .wb_val                (wb_val),
      .wb_rd                 (wb_rd),
      .wb_data               (wb_data),
      .wb_rdy                (wb_rdy),
      .busy_mask             (busy_mask),
      .inflight              (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        mulh;
      logic [63:0] res;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } sb_t;

   vec_t        vecs [6];
   sb_t         sb [$];
   logic [63:0] rq [$];
   int          checks = 0;
   int          errors = 0;
   logic        resp_en = 1'b0;
   logic [63:0] pend_res = '0;
   logic [31:0] pend_exp = '0;
   logic [4:0]  pend_rd = '0;
   int          run_len = 0;
   int          max_run = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Unit model and writeback scoreboard: sample at negedge, drive just after posedge.
   initial begin
      muldivresp_val        = 1'b0;
      muldivresp_msg_result = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            sb.delete();
            rq.delete();
            run_len = 0;
         end else begin
            if (wb_val && wb_rdy) begin
               run_len++;
               if (run_len > max_run) max_run = run_len;
               if (sb.size() == 0) begin
                  chk("wb_unexpected", 1, 0);
               end else begin
                  chk("wb_rd", wb_rd, sb[0].rd);
                  chk("wb_data", wb_data, sb[0].data);
                  void'(sb.pop_front());
               end
            end else begin
               run_len = 0;
            end
            if (muldivresp_val && muldivresp_rdy) void'(rq.pop_front());
            if (muldivreq_val && muldivreq_rdy) begin
               rq.push_back(pend_res);
               sb.push_back('{pend_rd, pend_exp});
            end
         end
         @(posedge clk);
         #2;
         muldivresp_val        = resp_en && (rq.size() != 0);
         muldivresp_msg_result = (rq.size() != 0) ? rq[0] : 64'd0;
      end
   end

   task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic mulh, input logic [63:0] res,
                        input logic [31:0] exp, output int waited);
      pend_res = res;
      pend_exp = exp;
      pend_rd  = rd;
      x_fn     = fn;
      x_a      = a;
      x_b      = b;
      x_rd     = rd;
      x_mulh   = mulh;
      x_val    = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!x_rdy && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!x_rdy) begin
         chk("issue_timeout", 1, 0);
      end else begin
         chk("req_fn", muldivreq_msg_fn, fn);
         chk("req_a", muldivreq_msg_a, a);
         chk("req_b", muldivreq_msg_b, b);
      end
      @(posedge clk);
      #1;
      x_val = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while (inflight != 0 && n < 500) begin
         n++;
         @(negedge clk);
      end
      chk("drain_inflight", inflight, 0);
      chk("drain_sb_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wb_val();
      int n = 0;
      while (!wb_val && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("wait_wb_val", wb_val, 1);
   endtask

   initial begin
      int w;
      logic [63:0] res;
      logic [2:0]  fn;

      vecs[0] = '{3'd0, 32'hffff_fff8, 32'h0000_0008, 5'd5, 1'b0,
                  64'hffff_ffff_ffff_ffc0, 32'hffff_ffc0};
      vecs[1] = '{3'd3, 32'h0000_0222, 32'h0000_0032, 5'd6, 1'b0,
                  64'h0000_002e_0000_000a, 32'h0000_002e};
      vecs[2] = '{3'd1, 32'h0000_0222, 32'h0000_0032, 5'd8, 1'b0,
                  64'h0000_002e_0000_000a, 32'h0000_000a};
      vecs[3] = '{3'd2, 32'h0000_0064, 32'h0000_0007, 5'd9, 1'b0,
                  64'h0000_0002_0000_000e, 32'h0000_000e};
      vecs[4] = '{3'd4, 32'h0000_0064, 32'h0000_0007, 5'd10, 1'b0,
                  64'h0000_0002_0000_000e, 32'h0000_0002};
`ifdef RISCV_MULDIV_ISSUE_MULH_EN
      vecs[5] = '{3'd0, 32'hdead_beef, 32'h1000_0000, 5'd11, 1'b1,
                  64'hfdea_dbee_f000_0000, 32'hfdea_dbee};
`else
      vecs[5] = '{3'd0, 32'hdead_beef, 32'h1000_0000, 5'd11, 1'b1,
                  64'hfdea_dbee_f000_0000, 32'hf000_0000};
`endif

      reset_n       = 1'b0;
      x_val         = 1'b0;
      x_fn          = '0;
      x_a           = '0;
      x_b           = '0;
      x_rd          = '0;
      x_mulh        = 1'b0;
      muldivreq_rdy = 1'b1;
      wb_rdy        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_wb_val", wb_val, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_req_val", muldivreq_val, 0);
      chk("rst_resp_rdy", muldivresp_rdy, 0);
      chk("rst_x_rdy", x_rdy, 1);
      @(posedge clk);
      #1;

      // Mul lo with one-cycle response-to-writeback latency
      issue(vecs[0].fn, vecs[0].a, vecs[0].b, vecs[0].rd, vecs[0].mulh, vecs[0].res,
            vecs[0].exp, w);
      @(negedge clk);
      chk("lat_busy5_set", busy_mask[5], 1);
      chk("lat_inflight1", inflight, 1);
      chk("lat_wb_idle", wb_val, 0);
      @(posedge clk);
      #1;
      resp_en = 1'b1;
      @(negedge clk);
      chk("lat_resp_fire", muldivresp_val & muldivresp_rdy, 1);
      chk("lat_wb_before", wb_val, 0);
      @(negedge clk);
      chk("lat_wb_val", wb_val, 1);
      chk("lat_wb_rd", wb_rd, 5);
      chk("lat_wb_data", wb_data, 32'hffff_ffc0);
      chk("lat_busy5_held", busy_mask[5], 1);
      @(posedge clk);
      #1;
      wb_rdy = 1'b1;
      drain();
      chk("lat_busy5_clr", busy_mask[5], 0);

      // Vector table, one op at a time
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].mulh, vecs[i].res,
               vecs[i].exp, w);
         drain();
      end

      // Full FIFO backpressure, then in-order release
      resp_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         issue(3'd1, 32'(i * 100), 32'd3, 5'(i), 1'b0, {32'(i), 32'(i + 16)}, 32'(i + 16), w);
      end
      pend_res = 64'd0;
      pend_exp = 32'd0;
      pend_rd  = 5'd12;
      x_rd     = 5'd12;
      x_val    = 1'b1;
      @(negedge clk);
      chk("full_x_rdy", x_rdy, 0);
      chk("full_req_val", muldivreq_val, 0);
      chk("full_inflight", inflight, 4);
      chk("full_busy", busy_mask, 32'h0000_001e);
      @(posedge clk);
      #1;
      x_val   = 1'b0;
      resp_en = 1'b1;
      drain();

      // WAW on rd=7: blocked through the clearing cycle
      resp_en = 1'b0;
      issue(3'd0, 32'd3, 32'd5, 5'd7, 1'b0, 64'd15, 32'd15, w);
      pend_res = 64'h0000_0001_0000_0002;
      pend_exp = 32'h0000_0001;
      pend_rd  = 5'd7;
      x_fn     = 3'd3;
      x_rd     = 5'd7;
      x_val    = 1'b1;
      wb_rdy   = 1'b0;
      @(negedge clk);
      chk("waw_blocked", muldivreq_val, 0);
      chk("waw_x_rdy", x_rdy, 0);
      @(posedge clk);
      #1;
      resp_en = 1'b1;
      @(negedge clk);
      wait_wb_val();
      chk("waw_blocked_wbfull", muldivreq_val, 0);
      @(posedge clk);
      #1;
      wb_rdy = 1'b1;
      @(negedge clk);
      chk("waw_clear_cycle_fire", wb_val & wb_rdy, 1);
      chk("waw_clear_cycle_blk", muldivreq_val, 0);
      @(negedge clk);
      chk("waw_released", muldivreq_val, 1);
      @(posedge clk);
      #1;
      x_val = 1'b0;
      drain();

      // x0 never blocks or marks busy
      resp_en = 1'b0;
      issue(3'd0, 32'd2, 32'd2, 5'd0, 1'b0, 64'd4, 32'd4, w);
      chk("x0_first_wait", w, 0);
      issue(3'd0, 32'd3, 32'd3, 5'd0, 1'b0, 64'd9, 32'd9, w);
      chk("x0_second_wait", w, 0);
      @(negedge clk);
      chk("x0_busy", busy_mask, 0);
      chk("x0_inflight", inflight, 2);
      @(posedge clk);
      #1;
      resp_en = 1'b1;
      drain();

      // Back-to-back throughput, one op per cycle
      for (int i = 0; i < 8; i++) begin
         fn  = (i % 2 == 1) ? 3'd3 : 3'd0;
         res = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
         issue(fn, 32'(i), 32'd1, 5'(i + 1), 1'b0, res,
               (fn == 3'd3) ? res[63:32] : res[31:0], w);
      end
      drain();
      chk("thru_run8", max_run >= 8, 1);

      // Writeback stall holds data and blocks responses
      wb_rdy = 1'b0;
      issue(3'd0, 32'd1, 32'd1, 5'd20, 1'b0, 64'h1111_2222_3333_4444, 32'h3333_4444, w);
      issue(3'd3, 32'd1, 32'd1, 5'd21, 1'b0, 64'h5555_6666_7777_8888, 32'h5555_6666, w);
      @(negedge clk);
      wait_wb_val();
      for (int i = 0; i < 3; i++) begin
         chk("stall_wb_data", wb_data, 32'h3333_4444);
         chk("stall_resp_rdy", muldivresp_rdy, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      wb_rdy = 1'b1;
      drain();

      // Async reset mid-cycle with ops in flight
      resp_en = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         issue(3'd2, 32'd9, 32'd2, 5'(i), 1'b0, 64'd0, 32'd0, w);
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy_mask, 0);
      chk("rst_mid_inflight", inflight, 0);
      chk("rst_mid_wb_val", wb_val, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      resp_en = 1'b1;
      issue(vecs[1].fn, vecs[1].a, vecs[1].b, vecs[1].rd, vecs[1].mulh, vecs[1].res,
            vecs[1].exp, w);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
